baud_gen_frac: RTL and testbench

- Runtime-programmable baud/oversample tick generator with a fractional divisor.
- Successor to the fixed-divisor generator. Supports a configurable oversample ratio, glitch-free divisor updates at bit boundaries, a clock enable, and phase resync for the RX start-bit edge.
- Sits between the system clock and the UART TX/RX engines. Drives tick_os (RX sampling) and baud_tick (TX bit strobe), which are phase-aligned.

---
 rtl/baud_gen_frac.sv | 109 ++++++++++
 tb/tb_baud_gen_frac.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// rtl/baud_gen_frac.sv - fractional-divisor baud / oversample tick generator
module baud_gen_frac #(
  parameter int DIV_W          = 16,
  parameter int FRAC_W         = 4,
  parameter int OVERSAMPLE     = 16,
  parameter int RESET_DIV_INT  = 325,
  parameter int RESET_DIV_FRAC = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          resync,
  input  logic                          cfg_valid,
  input  logic [DIV_W-1:0]              cfg_div_int,
  input  logic [FRAC_W-1:0]             cfg_div_frac,
  output logic                          cfg_pending,
  output logic                          tick_os,
  output logic                          baud_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] sample_idx
);

  localparam int IDX_W = $clog2(OVERSAMPLE);
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(OVERSAMPLE - 1);
  localparam logic [DIV_W-1:0]  RST_INT  = (RESET_DIV_INT < 2) ? DIV_W'(2) : DIV_W'(RESET_DIV_INT);
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RESET_DIV_FRAC);

  // Divisors below 2 cannot produce a one-cycle pulse followed by a gap.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic [DIV_W-1:0]  pend_int;
  logic [FRAC_W-1:0] pend_frac;
  logic [FRAC_W-1:0] acc;
  logic [DIV_W-1:0]  cnt;

  logic [FRAC_W:0]   acc_sum;
  logic [DIV_W-1:0]  reload_cnt;
  logic [DIV_W-1:0]  pend_eff;
  logic              at_zero;
  logic              at_bit_end;

  // The carry out of the accumulator stretches the next period by one clock.
  assign acc_sum    = {1'b0, acc} + {1'b0, div_frac};
  assign reload_cnt = div_int - DIV_W'(1) + {{(DIV_W-1){1'b0}}, acc_sum[FRAC_W]};
  assign pend_eff   = clamp_div(pend_int);
  assign at_zero    = (cnt == '0);
  assign at_bit_end = (sample_idx == IDX_MAX);

  // Tick timing, phase resync and glitch-free divisor switch at bit boundaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_int     <= RST_INT;
      div_frac    <= RST_FRAC;
      pend_int    <= '0;
      pend_frac   <= '0;
      cfg_pending <= 1'b0;
      acc         <= '0;
      cnt         <= RST_INT - DIV_W'(1);
      sample_idx  <= IDX_MAX;
      tick_os     <= 1'b0;
      baud_tick   <= 1'b0;
    end else begin
      tick_os   <= 1'b0;
      baud_tick <= 1'b0;
      if (en) begin
        if (resync) begin
          // Restart the bit phase now; a pending config takes effect immediately.
          acc        <= '0;
          sample_idx <= IDX_MAX;
          if (cfg_pending) begin
            div_int     <= pend_eff;
            div_frac    <= pend_frac;
            cnt         <= pend_eff - DIV_W'(1);
            cfg_pending <= 1'b0;
          end else begin
            cnt <= div_int - DIV_W'(1);
          end
        end else if (at_zero) begin
          tick_os    <= 1'b1;
          sample_idx <= sample_idx + IDX_W'(1);
          baud_tick  <= at_bit_end;
          if (at_bit_end && cfg_pending) begin
            // Bit boundary: switch divisors with a clean accumulator.
            div_int     <= pend_eff;
            div_frac    <= pend_frac;
            acc         <= '0;
            cnt         <= pend_eff - DIV_W'(1);
            cfg_pending <= 1'b0;
          end else begin
            acc <= acc_sum[FRAC_W-1:0];
            cnt <= reload_cnt;
          end
        end else begin
          cnt <= cnt - DIV_W'(1);
        end
      end
      // Capture after apply so a coincident write stays pending (last write wins).
      if (cfg_valid) begin
        pend_int    <= cfg_div_int;
        pend_frac   <= cfg_div_frac;
        cfg_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb/tb_baud_gen_frac.sv - scoreboard bench for baud_gen_frac
module tb_baud_gen_frac;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        resync;
  logic        cfg_valid;
  logic [15:0] cfg_div_int;
  logic [3:0]  cfg_div_frac;
  logic        cfg_pending;
  logic        tick_os;
  logic        baud_tick;
  logic [3:0]  sample_idx;

  baud_gen_frac dut (
    .clk(clk), .reset(reset), .en(en), .resync(resync),
    .cfg_valid(cfg_valid), .cfg_div_int(cfg_div_int), .cfg_div_frac(cfg_div_frac),
    .cfg_pending(cfg_pending), .tick_os(tick_os), .baud_tick(baud_tick),
    .sample_idx(sample_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit baud;
    int idx;
  } exp_t;

  exp_t q[$];
  bit   track = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_idx = 15;
  int   r, t, c0;

  // Monitor: every tick seen while tracking must match the head of the queue.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (track && baud_tick && !tick_os) begin
      checks++;
      errors++;
      $display("FAIL baud_without_tick: cyc=%0d baud_tick=1 tick_os=0, required tick_os=1", cyc);
    end
    if (track && tick_os) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick: cyc=%0d sample_idx=%0d, required no tick", cyc, sample_idx);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc || baud_tick != e.baud || int'(sample_idx) != e.idx) begin
          errors++;
          $display("FAIL tick: got cyc=%0d baud=%0d idx=%0d, required cyc=%0d baud=%0d idx=%0d",
                   cyc, baud_tick, sample_idx, e.cyc, e.baud, e.idx);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_one(input int c);
    exp_t e;
    exp_idx = (exp_idx + 1) % 16;
    e.cyc  = c;
    e.baud = (exp_idx == 0);
    e.idx  = exp_idx;
    q.push_back(e);
  endtask

  // Tick n lands at start + n*dint + floor((n-1)*dfrac/16) after the period start.
  task automatic push_ticks(input int start, input int dint, input int dfrac, input int n);
    for (int k = 1; k <= n; k++) push_one(start + k * dint + ((k - 1) * dfrac) / 16);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d ticks outstanding, required 0", name, q.size());
      q.delete();
    end
    track = 1'b0;
  endtask

  task automatic cfg_resync(input int di, input int df);
    cfg_div_int  = 16'(di);
    cfg_div_frac = 4'(df);
    cfg_valid    = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("pending_after_capture", int'(cfg_pending), 1);
    resync = 1'b1;
    step();
    resync = 1'b0;
    chk("pending_after_resync", int'(cfg_pending), 0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; resync = 1'b0; cfg_valid = 1'b0;
    cfg_div_int = '0; cfg_div_frac = '0;
    repeat (3) step();
    chk("rst_tick_os", int'(tick_os), 0);
    chk("rst_baud_tick", int'(baud_tick), 0);
    chk("rst_cfg_pending", int'(cfg_pending), 0);
    chk("rst_sample_idx", int'(sample_idx), 15);

    // Default divisor 325/8 from reset.
    reset = 1'b0; en = 1'b1; c0 = cyc;
    exp_idx = 15;
    push_ticks(c0, 325, 8, 17);
    track = 1'b1;
    drain("reset_default", 6000);

    // Fractional 4/8: periods 4,4,5,4,5...; 32 ticks span 143 cycles.
    cfg_resync(4, 8);
    r = cyc; exp_idx = 15;
    push_ticks(r, 4, 8, 33);
    track = 1'b1;
    drain("frac", 300);

    // Boundary apply of 10/0 while running at 4/0.
    cfg_resync(4, 0);
    r = cyc; exp_idx = 15;
    push_ticks(r, 4, 0, 17);
    track = 1'b1;
    wait_to(r + 10);
    cfg_div_int = 16'd10; cfg_div_frac = 4'd0; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("pending_midbit", int'(cfg_pending), 1);
    wait_to(r + 67);
    chk("pending_before_boundary", int'(cfg_pending), 1);
    step();
    chk("pending_after_boundary", int'(cfg_pending), 0);
    push_ticks(r + 68, 10, 0, 2);
    drain("boundary", 200);

    // Enable freeze for 7 cycles at cnt=2 with divisor 10.
    t = r + 88;
    wait_to(t + 7);
    push_one(t + 17);
    push_one(t + 27);
    track = 1'b1;
    en = 1'b0;
    wait_to(t + 14);
    en = 1'b1;
    drain("freeze", 100);

    // Resync one cycle before cnt==0 suppresses that tick.
    cfg_resync(4, 0);
    r = cyc; exp_idx = 15;
    push_one(r + 4);
    push_one(r + 8);
    track = 1'b1;
    wait_to(r + 10);
    resync = 1'b1;
    step();
    resync = 1'b0;
    exp_idx = 15;
    push_one(r + 15);
    push_one(r + 19);
    drain("resync_priority", 60);

    // Divisor 1 clamps to 2.
    cfg_resync(1, 0);
    r = cyc; exp_idx = 15;
    for (int k = 1; k <= 5; k++) push_one(r + 2 * k);
    track = 1'b1;
    drain("clamp", 40);

    // Reset mid-count with a config pending; reset beats resync and cfg_valid.
    cfg_resync(4, 0);
    r = cyc;
    wait_to(r + 5);
    cfg_div_int = 16'd10; cfg_div_frac = 4'd0; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("pending_before_reset", int'(cfg_pending), 1);
    reset = 1'b1; resync = 1'b1; cfg_valid = 1'b1;
    cfg_div_int = 16'd7; cfg_div_frac = 4'd3;
    step();
    chk("midrst_tick_os", int'(tick_os), 0);
    chk("midrst_baud_tick", int'(baud_tick), 0);
    chk("midrst_cfg_pending", int'(cfg_pending), 0);
    chk("midrst_sample_idx", int'(sample_idx), 15);
    reset = 1'b0; resync = 1'b0; cfg_valid = 1'b0;
    c0 = cyc; exp_idx = 15;
    push_ticks(c0, 325, 8, 3);
    track = 1'b1;
    drain("reset_mid", 1100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
